// File: rtl/stdp_pkg.sv
// Shared types and constants for the STDP weight-update stage.
package stdp_pkg;

  typedef enum logic {
    IDLE,
    COLLECT
  } stdp_state_e;

  typedef enum logic [1:0] {
    NONE,
    CAPTURE,
    BACKOFF,
    SEARCH
  } stdp_case_e;

  // Fibonacci taps 16,14,13,11 mapped onto state bits 15,13,12,10.
  localparam logic [15:0] STDP_LFSR_TAPS = 16'hB400;

  function automatic stdp_case_e stdp_classify(input logic in_seen,
                                               input logic out_seen,
                                               input logic in_first);
    stdp_case_e kind;
    kind = NONE;
    if (in_seen && out_seen) kind = in_first ? CAPTURE : BACKOFF;
    else if (in_seen)        kind = SEARCH;
    else if (out_seen)       kind = BACKOFF;
    return kind;
  endfunction

endpackage

// File: rtl/stdp_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; the feedback bit enters at bit 0.
module stdp_lfsr16
  import stdp_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEED;
    else     state <= {state[14:0], ^(state & STDP_LFSR_TAPS)};
  end

endmodule

// File: rtl/stdp_update_gen.sv
// STDP update stage: classifies each gamma frame and issues one inc/dec pulse to the weight counter.
// Define STDP_STOCHASTIC_EN to gate each pulse with an LFSR-driven probability threshold.
module stdp_update_gen
  import stdp_pkg::*;
#(
  parameter int unsigned WEIGHT_W  = 3,
  parameter int unsigned TIME_W    = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [7:0]  P_CAPTURE = 8'd255,
  parameter logic [7:0]  P_BACKOFF = 8'd255,
  parameter logic [7:0]  P_SEARCH  = 8'd16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                gamma,
  input  logic                learn_en,
  input  logic                in_spike,
  input  logic                out_spike,
  input  logic [WEIGHT_W-1:0] weight,
  output logic                inc,
  output logic                dec
);

  localparam logic [TIME_W-1:0] T_MAX = '1;

  stdp_state_e       state_q, state_d;
  stdp_case_e        kind;
  logic [TIME_W-1:0] tcnt, t_now, t_in, t_out;
  logic              in_seen, out_seen;
  logic [7:0]        thr, rnd;
  logic              fire, classify, inc_d, dec_d;

`ifdef STDP_STOCHASTIC_EN
  localparam bit STOCH = 1'b1;
  logic [15:0] lfsr;

  stdp_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign rnd = lfsr[7:0];
`else
  localparam bit STOCH = 1'b0;
  assign rnd = 8'h00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (gamma) state_d = COLLECT;
  end

  // tcnt holds the intra-frame time of the current cycle; the gamma cycle itself is time 0.
  assign t_now = gamma ? '0 : tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tcnt <= '0;
    else if (gamma)         tcnt <= TIME_W'(1);
    else if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;
  end

  // A spike coincident with gamma opens the new frame rather than closing the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_seen  <= 1'b0;
      out_seen <= 1'b0;
      t_in     <= '0;
      t_out    <= '0;
    end else if (gamma) begin
      in_seen  <= in_spike;
      out_seen <= out_spike;
      t_in     <= '0;
      t_out    <= '0;
    end else if (state_q == COLLECT) begin
      if (in_spike && !in_seen) begin
        in_seen <= 1'b1;
        t_in    <= t_now;
      end
      if (out_spike && !out_seen) begin
        out_seen <= 1'b1;
        t_out    <= t_now;
      end
    end
  end

  assign kind = stdp_classify(in_seen, out_seen, t_in <= t_out);

  always_comb begin
    thr = 8'd0;
    unique case (kind)
      CAPTURE: thr = P_CAPTURE;
      BACKOFF: thr = P_BACKOFF;
      SEARCH:  thr = P_SEARCH;
      default: thr = 8'd0;
    endcase
  end

  assign fire     = !STOCH || (rnd < thr);
  assign classify = gamma && (state_q == COLLECT) && learn_en && fire;
  // Pulses the saturating counter would ignore are dropped here.
  assign inc_d    = classify && ((kind == CAPTURE) || (kind == SEARCH)) && (weight != '1);
  assign dec_d    = classify && (kind == BACKOFF) && (weight != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc <= 1'b0;
      dec <= 1'b0;
    end else begin
      inc <= inc_d;
      dec <= dec_d;
    end
  end

endmodule
